tick_gen_multi: RTL and testbench
=================================

Name: tick_gen_multi

Overview:
- Multi-channel programmable tick generator. Parametrised successor of the fixed 100 Hz tick generator.
- N_CH independent channels, each emitting a one-clock tick every DIV clocks.
- Per-channel divisor is runtime-writable (shadowed, applied at period boundary); per-channel enable; global phase-sync restart.
- Feeds debouncers, scan drivers and timers that need different tick rates from one block.

Parameters:
- N_CH, 4, number of tick channels (1..16).
- MAX_DIV, 1_000_000, largest legal divisor; sets CNT_W = $clog2(MAX_DIV+1).
- DEF_DIV, 1_000_000, reset divisor for every channel (100 Hz at 100 MHz clk); must satisfy 1 <= DEF_DIV <= MAX_DIV.
- STRETCH, 1, tick high width in clocks; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_en  in  N_CH  per-channel count enable, bit k = channel k.
- i_sync  in  1  one-cycle pulse: restart all channels phase-aligned.
- i_div_we  in  1  divisor write strobe.
- i_div_sel  in  SEL_W  channel select, SEL_W = max(1,$clog2(N_CH)).
- i_div_val  in  CNT_W  new divisor value.
- o_tick  out  N_CH  per-channel tick.
- o_tick_any  out  1  registered OR of all channel ticks, same cycle as o_tick.

Behaviour:
- Reset (rst_n low, async):
  - cnt[k]=0, o_tick=0, o_tick_any=0.
  - div_act[k]=DEF_DIV, div_shd[k]=DEF_DIV.
- Per channel k, each clk edge, in priority order:
  1. i_sync=1: cnt<=0; o_tick[k]<=0; div_act<=div_shd (including a same-cycle write, see below). Sync overrides terminal count; no tick that cycle.
  2. i_en[k]=0: cnt holds; o_tick[k]<=0; div_act<=div_shd.
  3. cnt==div_act-1: cnt<=0; o_tick[k]<=1; div_act<=div_shd.
  4. Otherwise: cnt<=cnt+1; o_tick[k]<=0.
- Timing:
  - o_tick is registered and high exactly 1 clock.
  - Tick period = div_act clocks.
  - First tick is asserted on the edge after the div_act-th enabled clock counted from reset, sync or enable.
- div_act=1: cnt stays 0 and o_tick[k] is held high continuously while enabled.
- Divisor write (i_div_we=1):
  - div_shd[i_div_sel] <= clamp(i_div_val).
  - Clamp: 0 becomes 1; values above MAX_DIV become MAX_DIV.
  - i_div_sel >= N_CH: write ignored, no state change.
- Write coinciding with an apply event (sync, disabled channel, or terminal count) on the same channel: the written value is forwarded straight into div_act.
- The active period is never changed mid-period while the channel is enabled and no sync occurs.
- o_tick_any <= |next o_tick, aligned with o_tick.
- Counter width is CNT_W. Since cnt < div_act <= MAX_DIV, no wrap-around is possible.

Optional Feature:
- Macro TICKGEN_STRETCH_EN.
- Defined: each o_tick[k] is held high for STRETCH clocks starting at the terminal-count edge.
  - A new terminal count during a stretch restarts the stretch.
  - Sync or disable clears the stretch immediately (o_tick[k]<=0 next edge).
  - If STRETCH >= div_act, the output stays high continuously.
- Undefined: STRETCH is ignored, the stretch counters are not synthesised, and ticks are exactly 1 clock.

Test Plan:
- Period check: N_CH=2, DEF_DIV=4, i_en=2'b11 after reset release → o_tick=2'b11 on clocks 4, 8, 12 after release, each 1 clock wide; o_tick_any matches.
- Shadow update: ch0 running DIV=4; write val=6 to sel=0 at cnt=1 → current period still 4; following periods 6; ch1 unaffected (4).
- Sync/phase: ch0 DIV=3, ch1 DIV=5, free-running; pulse i_sync → both restart, no tick that cycle; ch0 ticks 3 clocks later, ch1 5 clocks later; sync on a terminal-count cycle suppresses that tick.
- Edge values: write val=0 → acts as DIV=1, o_tick continuously high; write val=MAX_DIV+7 → period MAX_DIV; write sel=N_CH → no channel changes.
- Enable/reset mid-operation: drop i_en[0] at cnt=2 for 5 clocks → cnt holds, no ticks, then tick 2 clocks after re-enable (DIV=4); assert rst_n=0 mid-period → o_tick=0 and cnt=0 immediately (async), divisors return to DEF_DIV.
- With TICKGEN_STRETCH_EN, STRETCH=2, DIV=5 → tick high 2 clocks every 5; DIV=2 → tick held high continuously.

Source files
------------

// File: rtl/tick_gen_multi_if.sv
// Control/tick bundle for tick_gen_multi: per-channel enables, phase sync,
// divisor write port and the tick outputs.
interface tick_gen_multi_if #(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned MAX_DIV = 1_000_000
);
   localparam int unsigned CNT_W = $clog2(MAX_DIV + 1);
   localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [N_CH-1:0]  i_en;
   logic             i_sync;
   logic             i_div_we;
   logic [SEL_W-1:0] i_div_sel;
   logic [CNT_W-1:0] i_div_val;
   logic [N_CH-1:0]  o_tick;
   logic             o_tick_any;

   modport master (
      output i_en, i_sync, i_div_we, i_div_sel, i_div_val,
      input  o_tick, o_tick_any
   );

   modport slave (
      input  i_en, i_sync, i_div_we, i_div_sel, i_div_val,
      output o_tick, o_tick_any
   );
endinterface

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator with shadowed per-channel divisors.
// Optional macro TICKGEN_STRETCH_EN widens each tick to STRETCH clocks.
module tick_gen_multi #(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned MAX_DIV = 1_000_000,
   parameter int unsigned DEF_DIV = 1_000_000,
   parameter int unsigned STRETCH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   tick_gen_multi_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(MAX_DIV + 1);
   localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [CNT_W-1:0] wr_val_c;
   logic [N_CH-1:0]  tick_nxt_c;
   logic [N_CH-1:0]  tick_q;
   logic             tick_any_q;

   // Clamp the written divisor into 1..MAX_DIV
   always_comb begin
      wr_val_c = bus.i_div_val;
      if (bus.i_div_val == '0)
         wr_val_c = CNT_W'(1);
      else if (bus.i_div_val > CNT_W'(MAX_DIV))
         wr_val_c = CNT_W'(MAX_DIV);
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] div_act_q;
      logic [CNT_W-1:0] div_shd_q;
      logic [CNT_W-1:0] shd_nxt_c;
      logic             wr_hit_c;
      logic             tc_c;
      logic             apply_c;
      logic             tick_c;

      // Out-of-range selects match no channel, so such writes are dropped
      assign wr_hit_c  = bus.i_div_we && (bus.i_div_sel == SEL_W'(k));
      assign shd_nxt_c = wr_hit_c ? wr_val_c : div_shd_q;
      assign tc_c      = (cnt_q == (div_act_q - CNT_W'(1)));
      assign apply_c   = bus.i_sync || !bus.i_en[k] || tc_c;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q     <= '0;
            div_act_q <= CNT_W'(DEF_DIV);
            div_shd_q <= CNT_W'(DEF_DIV);
         end else begin
            div_shd_q <= shd_nxt_c;
            // Same-cycle write is forwarded into the active divisor
            if (apply_c)
               div_act_q <= shd_nxt_c;
            if (bus.i_sync)
               cnt_q <= '0;
            else if (!bus.i_en[k])
               cnt_q <= cnt_q;
            else if (tc_c)
               cnt_q <= '0;
            else
               cnt_q <= cnt_q + CNT_W'(1);
         end
      end

`ifdef TICKGEN_STRETCH_EN
      localparam int unsigned STR_W = $clog2(STRETCH + 1);

      logic [STR_W-1:0] str_q;
      logic [STR_W-1:0] str_nxt_c;

      // Terminal count (re)loads the stretch; sync or disable kills it
      always_comb begin
         tick_c    = 1'b0;
         str_nxt_c = '0;
         if (bus.i_sync || !bus.i_en[k]) begin
            tick_c    = 1'b0;
            str_nxt_c = '0;
         end else if (tc_c) begin
            tick_c    = 1'b1;
            str_nxt_c = STR_W'(STRETCH - 1);
         end else if (str_q != '0) begin
            tick_c    = 1'b1;
            str_nxt_c = str_q - STR_W'(1);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            str_q <= '0;
         else
            str_q <= str_nxt_c;
      end
`else
      logic unused_stretch;

      assign unused_stretch = ^STRETCH;
      assign tick_c         = !bus.i_sync && bus.i_en[k] && tc_c;
`endif

      assign tick_nxt_c[k] = tick_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q     <= '0;
         tick_any_q <= 1'b0;
      end else begin
         tick_q     <= tick_nxt_c;
         tick_any_q <= |tick_nxt_c;
      end
   end

   assign bus.o_tick     = tick_q;
   assign bus.o_tick_any = tick_any_q;
endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: periods, shadow writes, sync, clamping,
// enable gaps, async reset; stretch scenario when TICKGEN_STRETCH_EN is set.
module tb_tick_gen_multi;
   localparam int unsigned N    = 3;
   localparam int unsigned MAXD = 20;
   localparam int unsigned DEFD = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_run  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   tick_gen_multi_if #(.N_CH(N), .MAX_DIV(MAXD)) bus ();

   tick_gen_multi #(.N_CH(N), .MAX_DIV(MAXD), .DEF_DIV(DEFD), .STRETCH(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef TICKGEN_STRETCH_EN
   tick_gen_multi_if #(.N_CH(N), .MAX_DIV(MAXD)) bus2 ();

   tick_gen_multi #(.N_CH(N), .MAX_DIV(MAXD), .DEF_DIV(DEFD), .STRETCH(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );
`endif

   // Expected tick vector c clocks after a phase-aligned start, per-channel periods
   function automatic logic [N-1:0] pat(input int c, input int p0, input int p1, input int p2);
      logic [N-1:0] r;
      r[0] = (c > 0) && (c % p0 == 0);
      r[1] = (c > 0) && (c % p1 == 0);
      r[2] = (c > 0) && (c % p2 == 0);
      return r;
   endfunction

   // Same, with each tick held for st clocks
   function automatic logic [N-1:0] pat_st(input int c, input int st, input int p0, input int p1, input int p2);
      logic [N-1:0] r;
      r[0] = (c >= p0) && (c % p0 < st);
      r[1] = (c >= p1) && (c % p1 < st);
      r[2] = (c >= p2) && (c % p2 < st);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_en      = '0;
      bus.i_sync    = 1'b0;
      bus.i_div_we  = 1'b0;
      bus.i_div_sel = '0;
      bus.i_div_val = '0;
`ifdef TICKGEN_STRETCH_EN
      bus2.i_en      = '0;
      bus2.i_sync    = 1'b0;
      bus2.i_div_we  = 1'b0;
      bus2.i_div_sel = '0;
      bus2.i_div_val = '0;
`endif
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      n_run++;
      if (bus.o_tick !== 3'b000 || bus.o_tick_any !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async tick=%b any=%b exp tick=000 any=0", bus.o_tick, bus.o_tick_any);
      end
      bus.i_en = 3'b111;
      step();
      n_run++;
      if (bus.o_tick !== 3'b000 || bus.o_tick_any !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_held tick=%b any=%b exp tick=000 any=0", bus.o_tick, bus.o_tick_any);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_period();
      logic [N-1:0] exp;
      do_reset();
      bus.i_en = 3'b111;
      for (int c = 1; c <= 12; c++) begin
         step();
         exp = pat(c, 4, 4, 4);
         n_run++;
         if (bus.o_tick !== exp || bus.o_tick_any !== (|exp)) begin
            n_fail++;
            $display("FAIL period c=%0d tick=%b any=%b exp tick=%b any=%b",
                     c, bus.o_tick, bus.o_tick_any, exp, |exp);
         end
      end
   endtask

   task automatic test_shadow();
      logic [N-1:0] exp;
      do_reset();
      bus.i_en = 3'b111;
      for (int c = 1; c <= 17; c++) begin
         bus.i_div_we  = (c == 2);
         bus.i_div_sel = 2'd0;
         bus.i_div_val = 5'd6;
         step();
         exp    = pat(c, 4, 4, 4);
         exp[0] = (c == 4) || (c == 10) || (c == 16);
         n_run++;
         if (bus.o_tick !== exp || bus.o_tick_any !== (|exp)) begin
            n_fail++;
            $display("FAIL shadow c=%0d tick=%b any=%b exp tick=%b any=%b",
                     c, bus.o_tick, bus.o_tick_any, exp, |exp);
         end
      end
      bus.i_div_we = 1'b0;
   endtask

   task automatic test_sync();
      logic [N-1:0] exp;
      do_reset();
      bus.i_div_we  = 1'b1;
      bus.i_div_sel = 2'd0;
      bus.i_div_val = 5'd3;
      step();
      bus.i_div_sel = 2'd1;
      bus.i_div_val = 5'd5;
      step();
      bus.i_div_we = 1'b0;
      n_run++;
      if (bus.o_tick !== 3'b000) begin
         n_fail++;
         $display("FAIL sync_disabled tick=%b exp=000", bus.o_tick);
      end
      bus.i_en = 3'b111;
      for (int c = 1; c <= 9; c++) begin
         bus.i_sync = (c == 9);
         step();
         exp = (c == 9) ? 3'b000 : pat(c, 3, 5, 4);
         n_run++;
         if (bus.o_tick !== exp || bus.o_tick_any !== (|exp)) begin
            n_fail++;
            $display("FAIL sync_pre c=%0d tick=%b any=%b exp tick=%b any=%b",
                     c, bus.o_tick, bus.o_tick_any, exp, |exp);
         end
      end
      bus.i_sync = 1'b0;
      for (int d = 1; d <= 10; d++) begin
         step();
         exp = pat(d, 3, 5, 4);
         n_run++;
         if (bus.o_tick !== exp || bus.o_tick_any !== (|exp)) begin
            n_fail++;
            $display("FAIL sync_post d=%0d tick=%b any=%b exp tick=%b any=%b",
                     d, bus.o_tick, bus.o_tick_any, exp, |exp);
         end
      end
   endtask

   task automatic test_edge_values();
      logic [N-1:0] exp;
      do_reset();
      bus.i_div_we  = 1'b1;
      bus.i_div_sel = 2'd0;
      bus.i_div_val = 5'd0;
      step();
      bus.i_div_sel = 2'd1;
      bus.i_div_val = 5'(MAXD + 7);
      step();
      bus.i_div_sel = 2'd3;
      bus.i_div_val = 5'd7;
      step();
      bus.i_div_we = 1'b0;
      bus.i_en     = 3'b111;
      for (int c = 1; c <= 41; c++) begin
         step();
         exp = pat(c, 1, int'(MAXD), 4);
         n_run++;
         if (bus.o_tick !== exp || bus.o_tick_any !== (|exp)) begin
            n_fail++;
            $display("FAIL edge c=%0d tick=%b any=%b exp tick=%b any=%b",
                     c, bus.o_tick, bus.o_tick_any, exp, |exp);
         end
      end
   endtask

   task automatic test_enable();
      logic [N-1:0] exp;
      do_reset();
      for (int c = 1; c <= 14; c++) begin
         bus.i_en = (c >= 3 && c <= 7) ? 3'b110 : 3'b111;
         step();
         exp    = pat(c, 4, 4, 4);
         exp[0] = (c == 9) || (c == 13);
         n_run++;
         if (bus.o_tick !== exp || bus.o_tick_any !== (|exp)) begin
            n_fail++;
            $display("FAIL enable c=%0d tick=%b any=%b exp tick=%b any=%b",
                     c, bus.o_tick, bus.o_tick_any, exp, |exp);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [N-1:0] exp;
      do_reset();
      bus.i_div_we  = 1'b1;
      bus.i_div_sel = 2'd0;
      bus.i_div_val = 5'd7;
      step();
      bus.i_div_we = 1'b0;
      bus.i_en     = 3'b111;
      for (int c = 1; c <= 4; c++) begin
         step();
         exp    = pat(c, 7, 4, 4);
         n_run++;
         if (bus.o_tick !== exp) begin
            n_fail++;
            $display("FAIL arst_pre c=%0d tick=%b exp=%b", c, bus.o_tick, exp);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      n_run++;
      if (bus.o_tick !== 3'b000 || bus.o_tick_any !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_mid tick=%b any=%b exp tick=000 any=0", bus.o_tick, bus.o_tick_any);
      end
      step();
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step();
         exp = pat(c, 4, 4, 4);
         n_run++;
         if (bus.o_tick !== exp || bus.o_tick_any !== (|exp)) begin
            n_fail++;
            $display("FAIL arst_post c=%0d tick=%b any=%b exp tick=%b any=%b",
                     c, bus.o_tick, bus.o_tick_any, exp, |exp);
         end
      end
   endtask

`ifdef TICKGEN_STRETCH_EN
   task automatic test_stretch();
      logic [N-1:0] exp;
      do_reset();
      bus2.i_div_we  = 1'b1;
      bus2.i_div_sel = 2'd0;
      bus2.i_div_val = 5'd5;
      step();
      bus2.i_div_sel = 2'd1;
      bus2.i_div_val = 5'd2;
      step();
      bus2.i_div_we = 1'b0;
      bus2.i_en     = 3'b111;
      for (int c = 1; c <= 12; c++) begin
         step();
         exp = pat_st(c, 2, 5, 2, 4);
         n_run++;
         if (bus2.o_tick !== exp || bus2.o_tick_any !== (|exp)) begin
            n_fail++;
            $display("FAIL stretch c=%0d tick=%b any=%b exp tick=%b any=%b",
                     c, bus2.o_tick, bus2.o_tick_any, exp, |exp);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_period();
      test_shadow();
      test_sync();
      test_edge_values();
      test_enable();
      test_async_reset();
`ifdef TICKGEN_STRETCH_EN
      test_stretch();
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
